dct1d_col_stage: RTL and testbench

//   Second-pass (column) 8-point 1-D integer DCT of the 2-D 8x8 JPEG DCT.

---
 rtl/dct1d_col_stage.sv | 122 ++++++++++++
 tb/tb_dct1d_col_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dct1d_col_stage.sv
// dct1d_col_stage: column pass of the 8x8 JPEG DCT (8-point 1-D integer DCT).
// Three register stages: butterfly, constant MAC, round/shift/saturate.
// Accepts one column per clock. The output is available 3 clocks after the input.
// A 3-bit beat counter raises o_last on the 8th output column of each block.
// Build option: define DCT_ROUND_EN to add +32 before the >>>6 (round half up).
// Without it, the result is a plain floor shift.
module dct1d_col_stage #(
  parameter int BW  = 9,
  parameter int OBW = 12
) (
  input  logic              i_clk,
  input  logic              i_Reset,
  input  logic              i_valid,
  input  logic [8*BW-1:0]   i_data,
  output logic              o_valid,
  output logic [8*OBW-1:0]  o_data,
  output logic              o_last
);
  localparam int SW   = BW + 1;
  localparam int ACCW = BW + 9;
  localparam int SH   = 6;
  localparam logic signed [ACCW-1:0] YMAX = ACCW'((1 << (OBW-1)) - 1);
  localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

  // Even rows (Y0,Y2,Y4,Y6) act on sums; odd rows (Y1,Y3,Y5,Y7) act on differences.
  localparam int CE [4][4] = '{'{23,  23,  23,  23},
                               '{30,  12, -12, -30},
                               '{23, -23, -23,  23},
                               '{12, -30,  30, -12}};
  localparam int CO [4][4] = '{'{31,  27,  18,   6},
                               '{27,  -6, -31, -18},
                               '{18, -31,   6,  27},
                               '{ 6, -18,  27, -31}};

  function automatic logic signed [ACCW-1:0] mac4(
    input logic signed [SW-1:0] a0, a1, a2, a3,
    input int c0, c1, c2, c3);
    mac4 = ACCW'(a0) * ACCW'(c0) + ACCW'(a1) * ACCW'(c1)
         + ACCW'(a2) * ACCW'(c2) + ACCW'(a3) * ACCW'(c3);
  endfunction

  logic signed [BW-1:0]   w_x   [8];
  logic signed [SW-1:0]   r_s   [4];
  logic signed [SW-1:0]   r_d   [4];
  logic signed [ACCW-1:0] r_acc [8];
  logic signed [ACCW-1:0] w_rnd [8];
  logic signed [ACCW-1:0] w_sh  [8];
  logic [OBW-1:0]         w_y   [8];
  logic [8*OBW-1:0]       w_ypk;
  logic [3:1]             r_vld;
  logic [2:0]             r_cnt;
  logic [8*OBW-1:0]       r_dat;
  logic                   r_last;

  for (genvar n = 0; n < 8; n++) begin : g_unpack
    assign w_x[n] = $signed(i_data[(7-n)*BW +: BW]);
  end

  // Stage 1: symmetric butterflies feeding the even/odd halves.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      for (int i = 0; i < 4; i++) begin
        r_s[i] <= '0;
        r_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_s[i] <= SW'(w_x[i]) + SW'(w_x[7-i]);
        r_d[i] <= SW'(w_x[i]) - SW'(w_x[7-i]);
      end
    end
  end

  // Stage 2: four-tap constant MAC per coefficient. The width is sized so it cannot overflow.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      for (int k = 0; k < 8; k++) r_acc[k] <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        r_acc[2*j]   <= mac4(r_s[0], r_s[1], r_s[2], r_s[3],
                             CE[j][0], CE[j][1], CE[j][2], CE[j][3]);
        r_acc[2*j+1] <= mac4(r_d[0], r_d[1], r_d[2], r_d[3],
                             CO[j][0], CO[j][1], CO[j][2], CO[j][3]);
      end
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_lane
`ifdef DCT_ROUND_EN
    assign w_rnd[k] = r_acc[k] + ACCW'(32);
`else
    assign w_rnd[k] = r_acc[k];
`endif
    assign w_sh[k] = w_rnd[k] >>> SH;
    // Clamp the scaled sum into the signed OBW output range.
    always_comb begin
      w_y[k] = w_sh[k][OBW-1:0];
      if (w_sh[k] > YMAX)      w_y[k] = YMAX[OBW-1:0];
      else if (w_sh[k] < YMIN) w_y[k] = YMIN[OBW-1:0];
    end
    assign w_ypk[(7-k)*OBW +: OBW] = w_y[k];
  end

  // Valid shift register and stage 3 output. Data is zeroed on idle beats so no stale column is visible.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      r_vld  <= '0;
      r_cnt  <= '0;
      r_dat  <= '0;
      r_last <= 1'b0;
    end else begin
      r_vld  <= {r_vld[2:1], i_valid};
      r_dat  <= r_vld[2] ? w_ypk : '0;
      r_last <= r_vld[2] && (r_cnt == 3'd7);
      if (r_vld[2]) r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_valid = r_vld[3];
  assign o_data  = r_dat;
  assign o_last  = r_last;
endmodule

// File: tb/tb_dct1d_col_stage.sv
// Directed bench for dct1d_col_stage. The expected coefficients are hand-derived constants.
// A second instance with OBW=9 covers output saturation.
module tb_dct1d_col_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        vin;
  logic [71:0] din;
  logic        vout, vout9, last, last9;
  logic [95:0] dout;
  logic [71:0] dout9;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stale = 0;
  logic [95:0] q_dat [$];
  logic        q_last[$];
  int          q_cyc [$];

  dct1d_col_stage #(.BW(9), .OBW(12)) dut (
    .i_clk(clk), .i_Reset(rst_n), .i_valid(vin), .i_data(din),
    .o_valid(vout), .o_data(dout), .o_last(last));

  dct1d_col_stage #(.BW(9), .OBW(9)) dut9 (
    .i_clk(clk), .i_Reset(rst_n), .i_valid(vin), .i_data(din),
    .o_valid(vout9), .o_data(dout9), .o_last(last9));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, then sample 1ns after the edge. Log the output beats and any stale data while idle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (vout) begin
      q_dat.push_back(dout);
      q_last.push_back(last);
      q_cyc.push_back(cyc);
    end else if (last || dout != '0) stale++;
  endtask

  task automatic qclr();
    q_dat.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  function automatic logic [71:0] mk8(input int x0, x1, x2, x3, x4, x5, x6, x7);
    int v[8];
    v = '{x0, x1, x2, x3, x4, x5, x6, x7};
    mk8 = '0;
    for (int n = 0; n < 8; n++) mk8[(7-n)*9 +: 9] = v[n][8:0];
  endfunction

  function automatic logic [95:0] yv(input int y0, y1, y2, y3, y4, y5, y6, y7);
    int v[8];
    v = '{y0, y1, y2, y3, y4, y5, y6, y7};
    yv = '0;
    for (int k = 0; k < 8; k++) yv[(7-k)*12 +: 12] = v[k][11:0];
  endfunction

  function automatic logic [95:0] yv9(input int y0);
    logic [71:0] r;
    r = '0;
    r[71:63] = y0[8:0];
    yv9 = {24'd0, r};
  endfunction

  // One column, then idle until it emerges 3 clocks later.
  task automatic send_one(input logic [71:0] d);
    vin = 1'b1; din = d; tick();
    vin = 1'b0; din = '0; tick(); tick();
  endtask

  int t0;
  logic [23:0] lv;
  int nbad;

  initial begin
    rst_n = 1'b0; vin = 1'b1; din = mk8(100,100,100,100,100,100,100,100);
    tick(); tick();
    chk("rst_valid", {95'd0, vout}, 96'd0);
    chk("rst_last",  {95'd0, last}, 96'd0);
    chk("rst_data",  dout, 96'd0);

    rst_n = 1'b1; vin = 1'b0; tick();

    // DC column: check the exact 3-clock latency.
    vin = 1'b1; din = mk8(100,100,100,100,100,100,100,100); tick();
    vin = 1'b0; din = '0;
    chk("dc_lat1", {95'd0, vout}, 96'd0);
    tick();
    chk("dc_lat2", {95'd0, vout}, 96'd0);
    tick();
    chk("dc_lat3", {95'd0, vout}, 96'd1);
`ifdef DCT_ROUND_EN
    chk("dc_data", dout, yv(288,0,0,0,0,0,0,0));
`else
    chk("dc_data", dout, yv(287,0,0,0,0,0,0,0));
`endif

    send_one(mk8(64,0,0,0,0,0,0,0));
    chk("impulse", dout, yv(23,31,30,27,23,18,12,6));

    // -1 impulse separates floor (-1 everywhere) from round-half-up (0 everywhere).
    send_one(mk8(-1,0,0,0,0,0,0,0));
`ifdef DCT_ROUND_EN
    chk("neg1", dout, yv(0,0,0,0,0,0,0,0));
`else
    chk("neg1", dout, yv(-1,-1,-1,-1,-1,-1,-1,-1));
`endif

    send_one(mk8(-256,-256,-256,-256,-256,-256,-256,-256));
    chk("min_in",      dout, yv(-736,0,0,0,0,0,0,0));
    chk("min_in_sat9", {24'd0, dout9}, yv9(-256));

    send_one(mk8(255,255,255,255,255,255,255,255));
    chk("max_in",      dout, yv(733,0,0,0,0,0,0,0));
    chk("max_in_sat9", {24'd0, dout9}, yv9(255));

    // Block framing: 16 columns, a 3-clock gap, then 8 more. Reset first so the counter starts at 0.
    rst_n = 1'b0; vin = 1'b0; tick();
    rst_n = 1'b1; qclr(); stale = 0;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin vin = 1'b1; din = mk8(64,0,0,0,0,0,0,0); tick(); end
    vin = 1'b0; din = '0;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 8; i++) begin vin = 1'b1; din = mk8(64,0,0,0,0,0,0,0); tick(); end
    vin = 1'b0; din = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("frm_count", 96'(q_dat.size()), 96'd24);
    if (q_dat.size() == 24) begin
      lv = '0;
      for (int i = 0; i < 24; i++) lv[i] = q_last[i];
      chk("frm_last", {72'd0, lv}, {72'd0, 24'h808080});
      chk("frm_lat",  96'(q_cyc[0] - t0), 96'd3);
      chk("frm_run",  96'(q_cyc[15] - q_cyc[0]), 96'd15);
      chk("frm_gap",  96'(q_cyc[16] - q_cyc[15]), 96'd4);
      chk("frm_data", q_dat[20], yv(23,31,30,27,23,18,12,6));
    end
    chk("idle_zero", 96'(stale), 96'd0);

    // Reset mid-block: in-flight columns are dropped and the counter restarts.
    for (int i = 0; i < 5; i++) begin vin = 1'b1; din = mk8(100,100,100,100,100,100,100,100); tick(); end
    rst_n = 1'b0; vin = 1'b0; din = '0; tick();
    rst_n = 1'b1; qclr();
    for (int i = 0; i < 8; i++) begin vin = 1'b1; din = mk8(64,0,0,0,0,0,0,0); tick(); end
    vin = 1'b0; din = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_count", 96'(q_dat.size()), 96'd8);
    if (q_dat.size() == 8) begin
      lv = '0; nbad = 0;
      for (int i = 0; i < 8; i++) begin
        lv[i] = q_last[i];
        if (q_dat[i] != yv(23,31,30,27,23,18,12,6)) nbad++;
      end
      chk("mid_last", {72'd0, lv}, {72'd0, 24'h000080});
      chk("mid_data", 96'(nbad), 96'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
